// File: rtl/unit_input_buf_if.sv
// Arbiter-to-unit byte stream with flow-control feedback.
// The arbiter side drives bytes; the unit side returns afull/ready.
interface unit_input_buf_if;
  logic [7:0] din;
  logic       din_ctrl;
  logic       wr_en;
  logic       afull;
  logic       ready;

  modport master (
    output din, din_ctrl, wr_en,
    input  afull, ready
  );

  modport slave (
    input  din, din_ctrl, wr_en,
    output afull, ready
  );
endinterface

// File: rtl/unit_input_buf.sv
// Per-unit receive stage: byte FIFO, framing parser,
// packet RAM packing and init decode with flow control.
module unit_input_buf #(
  parameter int WORD_MAX_LEN = 64,
  parameter int PKT_LEN      = WORD_MAX_LEN + 40,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_GAP    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  unit_input_buf_if.slave arb,
  output logic        pkt_valid,
  input  logic        pkt_consume,
  input  logic [4:0]  pkt_rd_addr,
  output logic [31:0] pkt_rd_data,
  output logic [4:0]  pkt_nwords,
  output logic [4:0]  init_data,
  output logic        init_valid,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 7;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DRAIN
  } state_t;

  state_t state, st_n;

  logic [8:0]    fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   occ, occ_n;
  logic          empty, full;
  logic          stall, pop, push, drop;
  logic [8:0]    head;
  logic          hctrl;
  logic [7:0]    hbyte;

  logic [31:0]   ram [32];
  logic          ram_we;
  logic [4:0]    ram_wa;
  logic [31:0]   ram_wd;

  logic [CW-1:0] cnt, cnt_n, total;
  logic [31:0]   acc, acc_n;
  logic          pv_n, iv_n, err_n;
  logic [4:0]    nw_n, id_n;
  logic          afull_q, ready_q;
  logic          afull_n, ready_n;

  assign empty = (occ == '0);
  assign full  = (occ == (AW+1)'(FIFO_DEPTH));
  assign head  = fifo[rp];
  assign hctrl = head[8];
  assign hbyte = head[7:0];

  // Hold a new data header until the core frees the packet RAM
  assign stall = (state == IDLE) & pkt_valid
               & hctrl & (hbyte == 8'h00);
  assign pop   = ~empty & ~stall;
  assign push  = arb.wr_en & (~full | pop);
  assign drop  = arb.wr_en & full & ~pop;
  assign occ_n = occ + (AW+1)'(push)
               - (AW+1)'(pop);

  assign total  = cnt + CW'(1);
  assign ram_wa = cnt[6:2];
  assign ram_wd = {hbyte, acc[23:0]};

  always_comb begin
    st_n   = state;
    cnt_n  = cnt;
    acc_n  = acc;
    pv_n   = pkt_valid;
    nw_n   = pkt_nwords;
    id_n   = init_data;
    iv_n   = 1'b0;
    err_n  = err | drop;
    ram_we = 1'b0;
    if (pkt_consume)
      pv_n = 1'b0;
    if (pop) begin
      unique case (state)
        IDLE: begin
          if (hctrl && hbyte[2:0] == 3'b001) begin
            id_n = hbyte[7:3];
            iv_n = 1'b1;
          end else if (hctrl && hbyte == 8'h00) begin
            st_n  = BODY;
            cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        BODY: begin
          acc_n[{cnt[1:0], 3'b000} +: 8] = hbyte;
          cnt_n = total;
          if (cnt[1:0] == 2'd3)
            ram_we = 1'b1;
          if (hctrl) begin
            st_n = IDLE;
            if (total[1:0] == 2'd0
                && total >= CW'(44)
                && total <= CW'(PKT_LEN)) begin
              pv_n = 1'b1;
              nw_n = total[6:2];
            end else begin
              err_n = 1'b1;
            end
          end else if (total == CW'(PKT_LEN)) begin
            err_n = 1'b1;
            st_n  = DRAIN;
          end
        end
        DRAIN: begin
          if (hctrl)
            st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  assign afull_n = occ_n
    >= (AW+1)'(FIFO_DEPTH - AFULL_GAP);
  assign ready_n = ~pv_n & (st_n == IDLE)
                 & (occ_n == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp         <= '0;
      rp         <= '0;
      occ        <= '0;
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      pkt_valid  <= 1'b0;
      pkt_nwords <= '0;
      init_data  <= '0;
      init_valid <= 1'b0;
      err        <= 1'b0;
      afull_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      occ        <= occ_n;
      state      <= st_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      pkt_valid  <= pv_n;
      pkt_nwords <= nw_n;
      init_data  <= id_n;
      init_valid <= iv_n;
      err        <= err_n;
      afull_q    <= afull_n;
      ready_q    <= ready_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      fifo[wp] <= {arb.din_ctrl, arb.din};
  end

  always_ff @(posedge CLK) begin
    if (ram_we)
      ram[ram_wa] <= ram_wd;
    pkt_rd_data <= ram[pkt_rd_addr];
  end

  assign arb.afull = afull_q;
  assign arb.ready = ready_q;

endmodule

// File: tb/tb_unit_input_buf.sv
// Directed bench for unit_input_buf: framing, packing,
// stall/afull back-pressure, length errors, drain and reset.
module tb_unit_input_buf;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        pkt_valid;
  logic        pkt_consume;
  logic [4:0]  pkt_rd_addr;
  logic [31:0] pkt_rd_data;
  logic [4:0]  pkt_nwords;
  logic [4:0]  init_data;
  logic        init_valid;
  logic        err;

  int total  = 0;
  int passed = 0;

  unit_input_buf_if bus ();

  unit_input_buf dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .arb         (bus),
    .pkt_valid   (pkt_valid),
    .pkt_consume (pkt_consume),
    .pkt_rd_addr (pkt_rd_addr),
    .pkt_rd_data (pkt_rd_data),
    .pkt_nwords  (pkt_nwords),
    .init_data   (init_data),
    .init_valid  (init_valid),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b,
                           input logic c);
    bus.din      = b;
    bus.din_ctrl = c;
    bus.wr_en    = 1'b1;
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic wait_afull_clear();
    int g = 0;
    while (bus.afull && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) begin
      total++;
      $display("FAIL afull_timeout afull=%0b exp 0",
               bus.afull);
    end
  endtask

  task automatic send_pkt(input int n,
                          input logic [7:0] base,
                          input logic lastc);
    logic [7:0] v;
    wait_afull_clear();
    push_byte(8'h00, 1'b1);
    for (int i = 0; i < n; i++) begin
      v = base + 8'(i);
      wait_afull_clear();
      push_byte(v, (i == n - 1) ? lastc : 1'b0);
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!pkt_valid && g < 300) begin
      tick();
      g++;
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!bus.ready && g < 300) begin
      tick();
      g++;
    end
  endtask

  task automatic rd(input logic [4:0] a,
                    output logic [31:0] d);
    pkt_rd_addr = a;
    tick();
    d = pkt_rd_data;
  endtask

  task automatic consume();
    pkt_consume = 1'b1;
    tick();
    pkt_consume = 1'b0;
  endtask

  task automatic test_reset();
    RST_N       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.din     = 8'h00;
    bus.din_ctrl = 1'b0;
    pkt_consume = 1'b0;
    pkt_rd_addr = '0;
    #2;
    total++;
    if (pkt_valid !== 1'b0)
      $display("FAIL rst_pkt_valid got %b exp 0", pkt_valid);
    else passed++;
    total++;
    if (err !== 1'b0)
      $display("FAIL rst_err got %b exp 0", err);
    else passed++;
    total++;
    if (bus.afull !== 1'b0)
      $display("FAIL rst_afull got %b exp 0", bus.afull);
    else passed++;
    total++;
    if (init_valid !== 1'b0 || init_data !== 5'd0)
      $display("FAIL rst_init got %b/%h exp 0/00",
               init_valid, init_data);
    else passed++;
    total++;
    if (pkt_nwords !== 5'd0)
      $display("FAIL rst_nwords got %0d exp 0", pkt_nwords);
    else passed++;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL rst_ready got %b exp 1", bus.ready);
    else passed++;
  endtask

  task automatic test_init();
    int pulses = 0;
    bus.din      = 8'h51;
    bus.din_ctrl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = (i < 2);
      tick();
      if (init_valid === 1'b1)
        pulses++;
    end
    bus.wr_en = 1'b0;
    total++;
    if (pulses != 2)
      $display("FAIL init_pulses got %0d exp 2", pulses);
    else passed++;
    total++;
    if (init_data !== 5'h0A)
      $display("FAIL init_data got %h exp 0a", init_data);
    else passed++;
    total++;
    if (err !== 1'b0)
      $display("FAIL init_err got %b exp 0", err);
    else passed++;
  endtask

  task automatic test_data_pkt();
    logic [31:0] d;
    send_pkt(44, 8'h00, 1'b1);
    wait_valid();
    total++;
    if (pkt_valid !== 1'b1)
      $display("FAIL data_valid got %b exp 1", pkt_valid);
    else passed++;
    total++;
    if (pkt_nwords !== 5'd11)
      $display("FAIL data_nwords got %0d exp 11", pkt_nwords);
    else passed++;
    total++;
    if (bus.ready !== 1'b0)
      $display("FAIL data_ready got %b exp 0", bus.ready);
    else passed++;
    rd(5'd0, d);
    total++;
    if (d !== 32'h03020100)
      $display("FAIL data_w0 got %h exp 03020100", d);
    else passed++;
    rd(5'd10, d);
    total++;
    if (d !== 32'h2B2A2928)
      $display("FAIL data_w10 got %h exp 2b2a2928", d);
    else passed++;
    consume();
    total++;
    if (pkt_valid !== 1'b0 || bus.ready !== 1'b1)
      $display("FAIL data_consume got v=%b r=%b exp v=0 r=1",
               pkt_valid, bus.ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  v;
    send_pkt(44, 8'h10, 1'b1);
    wait_valid();
    total++;
    if (pkt_valid !== 1'b1)
      $display("FAIL b2b_first got %b exp 1", pkt_valid);
    else passed++;
    push_byte(8'h00, 1'b1);
    for (int k = 1; k < 12; k++) begin
      v = 8'h80 + 8'(k - 1);
      push_byte(v, 1'b0);
      if (k == 10) begin
        total++;
        if (bus.afull !== 1'b0)
          $display("FAIL b2b_afull11 got %b exp 0", bus.afull);
        else passed++;
      end
    end
    total++;
    if (bus.afull !== 1'b1)
      $display("FAIL b2b_afull12 got %b exp 1", bus.afull);
    else passed++;
    consume();
    for (int k = 12; k <= 44; k++) begin
      v = 8'h80 + 8'(k - 1);
      wait_afull_clear();
      push_byte(v, (k == 44));
    end
    wait_valid();
    total++;
    if (pkt_valid !== 1'b1 || err !== 1'b0)
      $display("FAIL b2b_second got v=%b e=%b exp v=1 e=0",
               pkt_valid, err);
    else passed++;
    rd(5'd0, d);
    total++;
    if (d !== 32'h83828180)
      $display("FAIL b2b_w0 got %h exp 83828180", d);
    else passed++;
    rd(5'd10, d);
    total++;
    if (d !== 32'hABAAA9A8)
      $display("FAIL b2b_w10 got %h exp abaaa9a8", d);
    else passed++;
    consume();
  endtask

  task automatic test_bad_len();
    logic [31:0] d;
    send_pkt(45, 8'h00, 1'b1);
    wait_ready();
    total++;
    if (err !== 1'b1)
      $display("FAIL badlen_err got %b exp 1", err);
    else passed++;
    total++;
    if (pkt_valid !== 1'b0)
      $display("FAIL badlen_valid got %b exp 0", pkt_valid);
    else passed++;
    send_pkt(44, 8'h20, 1'b1);
    wait_valid();
    total++;
    if (pkt_valid !== 1'b1 || pkt_nwords !== 5'd11)
      $display("FAIL badlen_next got v=%b n=%0d exp v=1 n=11",
               pkt_valid, pkt_nwords);
    else passed++;
    rd(5'd1, d);
    total++;
    if (d !== 32'h27262524)
      $display("FAIL badlen_w1 got %h exp 27262524", d);
    else passed++;
    consume();
  endtask

  task automatic test_reset_mid();
    push_byte(8'h00, 1'b1);
    for (int i = 0; i < 20; i++)
      push_byte(8'(i), 1'b0);
    RST_N = 1'b0;
    #1;
    total++;
    if (err !== 1'b0)
      $display("FAIL rmid_err got %b exp 0", err);
    else passed++;
    total++;
    if (init_data !== 5'd0)
      $display("FAIL rmid_init got %h exp 00", init_data);
    else passed++;
    total++;
    if (pkt_nwords !== 5'd0 || pkt_valid !== 1'b0)
      $display("FAIL rmid_pkt got n=%0d v=%b exp n=0 v=0",
               pkt_nwords, pkt_valid);
    else passed++;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    total++;
    if (bus.ready !== 1'b1)
      $display("FAIL rmid_ready got %b exp 1", bus.ready);
    else passed++;
  endtask

  task automatic test_drain();
    push_byte(8'h00, 1'b1);
    for (int j = 1; j <= 120; j++) begin
      push_byte(8'(j), 1'b0);
      if (j == 103) begin
        total++;
        if (err !== 1'b0)
          $display("FAIL drain_err103 got %b exp 0", err);
        else passed++;
      end
      if (j == 106) begin
        total++;
        if (err !== 1'b1)
          $display("FAIL drain_err106 got %b exp 1", err);
        else passed++;
      end
    end
    repeat (3) tick();
    total++;
    if (bus.ready !== 1'b0)
      $display("FAIL drain_busy got %b exp 0", bus.ready);
    else passed++;
    push_byte(8'hEE, 1'b1);
    wait_ready();
    total++;
    if (bus.ready !== 1'b1 || pkt_valid !== 1'b0)
      $display("FAIL drain_idle got r=%b v=%b exp r=1 v=0",
               bus.ready, pkt_valid);
    else passed++;
    send_pkt(44, 8'h40, 1'b1);
    wait_valid();
    total++;
    if (pkt_valid !== 1'b1)
      $display("FAIL drain_next got %b exp 1", pkt_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_pkt();
    test_back_to_back();
    test_bad_len();
    test_reset_mid();
    test_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
